// File: rtl/nn_out_delta.sv
// Output-layer delta stage: reads the target for the current pattern, computes
// (y - t)*y*(1 - y) in signed Q2.14 and accumulates the epoch sum of squared error.
module nn_out_delta #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned FRAC   = 14,
  parameter int unsigned NPAT   = 16,
  parameter int unsigned SWIDTH = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              epoch_clr,
  input  logic [DWIDTH-1:0] y_in,
  output logic              t_rd,
  output logic [AWIDTH-1:0] t_addr,
  input  logic [DWIDTH-1:0] t_in,
  output logic [DWIDTH-1:0] delta_out,
  output logic              delta_valid,
  output logic [SWIDTH-1:0] sse_out,
  output logic              epoch_done,
  output logic              busy
);

  localparam int unsigned EW   = DWIDTH + 1;
  localparam int unsigned PW   = 2 * EW;
  localparam int unsigned SUMW = ((SWIDTH > PW) ? SWIDTH : PW) + 1;

  localparam logic [DWIDTH-1:0]    ONE  = DWIDTH'(1 << FRAC);
  localparam logic [AWIDTH-1:0]    LAST = AWIDTH'(NPAT - 1);
  localparam logic signed [PW-1:0] DMAX = PW'((2 ** (DWIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] DMIN = ~DMAX;
  localparam logic [SUMW-1:0]      AMAX = SUMW'({SWIDTH{1'b1}});

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_MUL1 = 3'd3;
  localparam logic [2:0] S_MUL2 = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [AWIDTH-1:0]      idx_q, idx_d;
  logic [SWIDTH-1:0]      acc_q, acc_d;
  logic [DWIDTH-1:0]      y_q, y_d;
  logic [DWIDTH-1:0]      t_q, t_d;
  logic signed [EW-1:0]   err_q, err_d;
  logic [DWIDTH-1:0]      ymy_q, ymy_d;
  logic [DWIDTH-1:0]      delta_q, delta_d;
  logic                   dvalid_q, dvalid_d;
  logic [SWIDTH-1:0]      sse_q, sse_d;
  logic                   edone_q, edone_d;
  logic                   t_rd_q, t_rd_d;
  logic                   busy_q, busy_d;

  logic [2*DWIDTH-1:0]    yprod_c;
  logic signed [PW-1:0]   err_ext_c, ymy_ext_c, dprod_c, dshift_c, sqprod_c;
  logic [PW-1:0]          sq_c;
  logic [SUMW-1:0]        sum_c;
  logic [SWIDTH-1:0]      acc_sat_c;
  logic [DWIDTH-1:0]      delta_sat_c;

  // Datapath arithmetic; y is clamped to 1.0 so y*(1-y) is never negative
  always_comb begin
    yprod_c     = (2*DWIDTH)'(y_q) * (2*DWIDTH)'(ONE - y_q);
    err_ext_c   = PW'(err_q);
    ymy_ext_c   = PW'(ymy_q);
    dprod_c     = err_ext_c * ymy_ext_c;
    dshift_c    = dprod_c >>> FRAC;
    sqprod_c    = err_ext_c * err_ext_c;
    sq_c        = $unsigned(sqprod_c >>> FRAC);
    sum_c       = SUMW'(acc_q) + SUMW'(sq_c);
    acc_sat_c   = (sum_c > AMAX) ? {SWIDTH{1'b1}} : SWIDTH'(sum_c);
    if (dshift_c > DMAX)      delta_sat_c = DWIDTH'(DMAX);
    else if (dshift_c < DMIN) delta_sat_c = DWIDTH'(DMIN);
    else                      delta_sat_c = DWIDTH'(dshift_c);
  end

  // Next-state logic; OUT accepts a new start so throughput is 5 cycles/pattern
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    y_d      = y_q;
    t_d      = t_q;
    err_d    = err_q;
    ymy_d    = ymy_q;
    delta_d  = delta_q;
    dvalid_d = 1'b0;
    sse_d    = sse_q;
    edone_d  = 1'b0;
    case (state_q)
      S_IDLE, S_OUT: begin
        state_d = S_IDLE;
        if (epoch_clr) begin
          idx_d = '0;
          acc_d = '0;
        end else if (start) begin
          y_d     = (y_in > ONE) ? ONE : y_in;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        t_d     = t_in;
        state_d = S_MUL1;
      end
      S_MUL1: begin
        err_d   = EW'(y_q) - EW'(t_q);
        ymy_d   = DWIDTH'(yprod_c >> FRAC);
        state_d = S_MUL2;
      end
      S_MUL2: begin
        delta_d  = delta_sat_c;
        dvalid_d = 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          sse_d   = acc_sat_c;
          acc_d   = '0;
          edone_d = 1'b1;
        end else begin
          idx_d = idx_q + AWIDTH'(1);
          acc_d = acc_sat_c;
        end
        state_d = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
    t_rd_d = (state_d == S_READ);
    busy_d = (state_d == S_READ) || (state_d == S_CAPT) ||
             (state_d == S_MUL1) || (state_d == S_MUL2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      t_q      <= '0;
      err_q    <= '0;
      ymy_q    <= '0;
      delta_q  <= '0;
      dvalid_q <= 1'b0;
      sse_q    <= '0;
      edone_q  <= 1'b0;
      t_rd_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      t_q      <= t_d;
      err_q    <= err_d;
      ymy_q    <= ymy_d;
      delta_q  <= delta_d;
      dvalid_q <= dvalid_d;
      sse_q    <= sse_d;
      edone_q  <= edone_d;
      t_rd_q   <= t_rd_d;
      busy_q   <= busy_d;
    end
  end

  assign t_rd        = t_rd_q;
  assign t_addr      = idx_q;
  assign delta_out   = delta_q;
  assign delta_valid = dvalid_q;
  assign sse_out     = sse_q;
  assign epoch_done  = edone_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_nn_out_delta.sv
// Bench for nn_out_delta: registered target memory model plus an integer
// reference model of delta, squared error and the epoch accumulator.
module tb_nn_out_delta;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        epoch_clr;
  logic [15:0] y_in;
  logic        t_rd;
  logic [3:0]  t_addr;
  wire  [15:0] t_in;
  logic [15:0] delta_out;
  logic        delta_valid;
  logic [23:0] sse_out;
  logic        epoch_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];
  logic [15:0] t_reg;
  logic        rd_d;

  int          m_idx;
  longint      m_acc;
  logic [23:0] m_sse;

  nn_out_delta dut (
    .clk(clk), .rst_n(rst_n), .start(start), .epoch_clr(epoch_clr),
    .y_in(y_in), .t_rd(t_rd), .t_addr(t_addr), .t_in(t_in),
    .delta_out(delta_out), .delta_valid(delta_valid), .sse_out(sse_out),
    .epoch_done(epoch_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered target memory: data valid the cycle after t_rd, Z otherwise
  always @(posedge clk) begin
    rd_d  <= t_rd;
    t_reg <= mem[t_addr];
  end
  assign t_in = rd_d ? t_reg : 16'bz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic from the Q2.14 definitions
  task automatic model(input logic [15:0] y, input logic [15:0] t,
                       output logic [15:0] d, output longint sq);
    longint yc, err, ymy, dl;
    yc  = (y > 16'h4000) ? 64'sd16384 : longint'(y);
    err = yc - longint'(t);
    ymy = (yc * (16384 - yc)) / 16384;
    dl  = (err * ymy) >>> 14;
    if (dl > 32767) dl = 32767;
    if (dl < -32768) dl = -32768;
    d  = 16'(dl);
    sq = (err * err) / 16384;
  endtask

  // Starts at the current negedge; checks every cycle up to delta_valid
  task automatic run_pattern(input logic [15:0] y, input int extra_start_at);
    logic [15:0] exp_d;
    longint      sq;
    bit          done;
    model(y, mem[m_idx], exp_d, sq);
    m_acc = m_acc + sq;
    if (m_acc > 64'hFF_FFFF) m_acc = 64'hFF_FFFF;
    done = (m_idx == 15);
    if (done) begin
      m_sse = 24'(m_acc);
      m_acc = 0;
      m_idx = 0;
    end else begin
      m_idx = m_idx + 1;
    end
    start = 1'b1; y_in = y;
    @(negedge clk);
    start = 1'b0;
    chk("t_rd_read", t_rd, 1);
    chk("t_addr_read", t_addr, done ? 15 : m_idx - 1);
    chk("busy_read", busy, 1);
    for (int k = 2; k <= 5; k++) begin
      if (k == extra_start_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (k == 2) chk("t_rd_capt", t_rd, 0);
      if (k < 5) begin
        chk("dvalid_early", delta_valid, 0);
        chk("busy_mid", busy, 1);
      end
    end
    chk("dvalid", delta_valid, 1);
    chk("delta", delta_out, exp_d);
    chk("epoch_done", epoch_done, done);
    chk("sse", sse_out, m_sse);
    chk("busy_out", busy, 0);
  endtask

  task automatic do_clear();
    epoch_clr = 1'b1;
    @(negedge clk);
    epoch_clr = 1'b0;
    m_idx = 0;
    m_acc = 0;
  endtask

  task automatic check_quiet(input string tag, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (delta_valid || t_rd) seen = 1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; epoch_clr = 1'b0; y_in = '0;
    for (int i = 0; i < 16; i++) mem[i] = (i % 2 == 0) ? 16'h4000 : 16'h0000;
    m_idx = 0; m_acc = 0; m_sse = '0;
    repeat (3) @(negedge clk);
    chk("rst_t_rd", t_rd, 0);
    chk("rst_t_addr", t_addr, 0);
    chk("rst_delta", delta_out, 0);
    chk("rst_dvalid", delta_valid, 0);
    chk("rst_sse", sse_out, 0);
    chk("rst_edone", epoch_done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pattern(16'h4000, 0);
    chk("delta_y1_t1", delta_out, 16'h0000);
    run_pattern(16'h2000, 0);
    chk("delta_t0", delta_out, 16'h0800);
    @(negedge clk);
    do_clear();
    run_pattern(16'h2000, 0);
    chk("delta_t1", delta_out, 16'hF800);

    // Full epoch back to back
    do_clear();
    for (int i = 0; i < 16; i++) run_pattern(16'h2000, 0);
    chk("sse_epoch", sse_out, 24'h010000);
    run_pattern(16'h2000, 0);

    // start while busy is dropped
    run_pattern(16'h3000, 3);
    check_quiet("busy_start_ignored", 8);

    run_pattern(16'h5000, 0);

    // start coinciding with epoch_clr
    @(negedge clk);
    start = 1'b1; epoch_clr = 1'b1; y_in = 16'h2000;
    @(negedge clk);
    start = 1'b0; epoch_clr = 1'b0;
    m_idx = 0; m_acc = 0;
    chk("clr_no_t_rd", t_rd, 0);
    chk("clr_no_busy", busy, 0);
    chk("clr_addr", t_addr, 0);
    chk("clr_sse_held", sse_out, m_sse);
    check_quiet("clr_quiet", 3);

    // Reset during MUL1
    run_pattern(16'h1000, 0);
    start = 1'b1; y_in = 16'h2000;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_t_rd", t_rd, 0);
    chk("mid_rst_addr", t_addr, 0);
    chk("mid_rst_delta", delta_out, 0);
    chk("mid_rst_dvalid", delta_valid, 0);
    chk("mid_rst_sse", sse_out, 0);
    chk("mid_rst_busy", busy, 0);
    m_idx = 0; m_acc = 0; m_sse = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("mid_rst_quiet", 6);
    run_pattern(16'h2000, 0);

    // Randomized targets and outputs over two epochs
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom_range(0, 16'hFFFF));
    @(negedge clk);
    do_clear();
    for (int i = 0; i < 32; i++) begin
      run_pattern(16'($urandom_range(0, 16'h5FFF)), 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_out_delta.md
Name: nn_out_delta

Overview:
- Output-layer error stage of the backpropagation network; sits directly downstream of the target-value memory.
- Per pattern: drives the memory's read enable and address, captures the 16-bit target t, and computes the output delta (y - t)*y*(1 - y) for the weight-update stage.
- Accumulates the sum of squared error over one epoch of NPAT patterns.

Parameters:
DWIDTH, 16, data width; unsigned Q2.14 for y/t, signed Q2.14 for err/delta
AWIDTH, 4, target-memory address width
FRAC, 14, fractional bits
NPAT, 16, patterns per epoch (1..2**AWIDTH)
SWIDTH, 24, squared-error accumulator width

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: y_in valid, process current pattern
epoch_clr  in  1  sync clear of pattern index and accumulator
y_in  in  DWIDTH  network output, unsigned Q2.14
t_rd  out  1  target-memory read enable (memory din)
t_addr  out  AWIDTH  target-memory address = current pattern index
t_in  in  DWIDTH  target value from memory, unsigned Q2.14; tristated when t_rd is low
delta_out  out  DWIDTH  signed Q2.14 output delta
delta_valid  out  1  one-cycle pulse, delta_out valid
sse_out  out  SWIDTH  epoch sum of squared error, unsigned Q(SWIDTH-14).14
epoch_done  out  1  one-cycle pulse, sse_out updated
busy  out  1  high from the cycle after start is accepted until delta_valid

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: all zero (t_rd=0, t_addr=0, delta_out=0, delta_valid=0, sse_out=0, epoch_done=0, busy=0).
  - Internal: state=IDLE, pattern index=0, accumulator=0.
  - Asserting rst_n mid-operation aborts the current pattern; no delta_valid is produced for it.
- FSM states and transitions:
  - IDLE: on start=1 and epoch_clr=0, register y_in clamped to 16'h4000 (1.0), so 1-y is never negative; go to READ.
  - READ: t_rd=1 for exactly this cycle; t_addr=index.
  - CAPT: memory output is registered and valid in this cycle; capture t_in.
  - MUL1: err = y - t (17-bit signed); ymy = (y*(16'h4000 - y)) >>> 14.
  - MUL2: delta = (err*ymy) >>> 14, saturated to the signed 16-bit range; sq = (err*err) >> 14.
  - OUT: update outputs (see below); return to IDLE.
- OUT cycle actions:
  - delta_out <= delta; delta_valid=1 for one cycle.
  - Accumulator += sq, saturating at 2**SWIDTH-1.
  - Index increments.
  - If index was NPAT-1: index wraps to 0, sse_out <= accumulator+sq, accumulator <= 0, epoch_done=1 in the same cycle as delta_valid.
- Latency: start in cycle N gives delta_valid in cycle N+5. Throughput is one pattern per 5 cycles.
- t_rd is low in all states except READ. t_in is never sampled outside CAPT, because it is Z there.
- start while busy is ignored; no queuing.
- epoch_clr: in IDLE it clears index and accumulator next cycle; sse_out is held. When start and epoch_clr coincide, the clear wins and start is dropped. epoch_clr while busy is ignored.
- Arithmetic: truncation toward -inf (arithmetic shift), no rounding. delta_out holds its value until the next OUT cycle.

Test Plan:
- Reset, then start with y_in=16'h4000 at index 0 (t=16'h4000) -> t_rd high cycle N+1 with t_addr=0; delta_valid at N+5, delta_out=16'h0000, accumulator +0.
- Index 1 (t=0), y_in=16'h2000 -> err=16'h2000, ymy=16'h1000, delta_out=16'h0800, accumulator +16'h1000.
- Index 0 (t=1.0), y_in=16'h2000 -> delta_out=16'hF800, accumulator +16'h1000.
- Full epoch, 16 starts with y_in=16'h2000 -> epoch_done coincides with the 16th delta_valid; sse_out=24'h010000; index back to 0; next read uses t_addr=0.
- Fault handling:
  - start pulsed during busy -> ignored, exactly one delta_valid.
  - y_in=16'h5000 -> treated as 16'h4000.
  - start with epoch_clr -> no t_rd, index=0.
- rst_n dropped during MUL1 -> all outputs zero immediately, no delta_valid; after release, next start reads t_addr=0.
